// File: rtl/excom_pkg.sv
// excom_pkg: shared definitions for the multi-channel event rate meter.
// Register offsets are relative to the block's BASE_ADDRESS. The bit indices
// locate fields inside CTRL and STATUS.
package excom_pkg;

    localparam logic [7:0] REG_CTRL        = 8'h00;
    localparam logic [7:0] REG_STATUS      = 8'h01;
    localparam logic [7:0] REG_GATE_MULT   = 8'h02;
    localparam logic [7:0] REG_OVF         = 8'h03;
    localparam logic [7:0] REG_RESULT_BASE = 8'h04;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_BOTH = 1;
    localparam int CTRL_CLR  = 2;

    localparam int STAT_NEW     = 0;
    localparam int STAT_OVF_ANY = 1;

    // Enabled, rising-edge counting.
    localparam logic [7:0] CTRL_DEFAULT = 8'h01;

endpackage

// File: rtl/excom_channel.sv
// excom_channel: one event-counting lane.
//   clk_i, rst_i    clock, async active-high reset
//   excom_i         asynchronous event input
//   both_mode_i     1 = count both edges, 0 = rising only
//   window_end_i    last cycle of the gate window (latch results)
//   clear_i         zero counter, pending flag, result and overflow
//   enable_i        0 holds counter and pending flag at zero
//   result_o        count latched at the last window end
//   ovf_o           channel saturated during the last completed window
//   pending_o       saturation seen in the current window
module excom_channel
    import excom_pkg::*;
#(
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   excom_i,
    input  logic                   both_mode_i,
    input  logic                   window_end_i,
    input  logic                   clear_i,
    input  logic                   enable_i,
    output logic [COUNT_WIDTH-1:0] result_o,
    output logic                   ovf_o,
    output logic                   pending_o
);

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    logic                   sync1_q, sync2_q, dly_q;
    logic [COUNT_WIDTH-1:0] cnt_q;
    logic [COUNT_WIDTH-1:0] result_q;
    logic                   pend_q;
    logic                   ovf_q;
    logic                   edge_det;

    assign edge_det  = both_mode_i ? (sync2_q ^ dly_q) : (sync2_q & ~dly_q);
    assign result_o  = result_q;
    assign ovf_o     = ovf_q;
    assign pending_o = pend_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
        end else begin
            sync1_q <= excom_i;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else if (clear_i) begin
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else if (!enable_i) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else if (window_end_i) begin
            result_q <= cnt_q;
            ovf_q    <= pend_q;
            // An edge detected on the boundary cycle belongs to the new window.
            cnt_q    <= edge_det ? COUNT_WIDTH'(1) : '0;
            pend_q   <= 1'b0;
        end else if (edge_det) begin
            if (cnt_q == CNT_MAX) begin
                pend_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/excom_multi.sv
// excom_multi: multi-channel external-event rate meter on the 8-bit bus.
//   clk, rst   system clock, async active-high reset
//   din        bus write data
//   address    bus address (block occupies BASE_ADDRESS .. +3+2*CHANNELS)
//   w_en       single-cycle write strobe
//   r_en       single-cycle read strobe
//   dout       registered read data, one cycle after r_en, else 0
//   excom      asynchronous event inputs, bit n = channel n
// Owns the gate timer, register decode, STATUS and the shared high-byte shadow.
module excom_multi
    import excom_pkg::*;
#(
    parameter logic [7:0] BASE_ADDRESS = 8'h00,
    parameter int         CHANNELS     = 4,
    parameter int         COUNT_WIDTH  = 8,
    parameter int         GATE_CYCLES  = 3200000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          din,
    input  logic [7:0]          address,
    input  logic                w_en,
    input  logic                r_en,
    output logic [7:0]          dout,
    input  logic [CHANNELS-1:0] excom
);

    localparam int            PW       = $clog2(GATE_CYCLES);
    localparam logic [PW-1:0] PRE_LAST = PW'(GATE_CYCLES - 1);

    logic          en_q, both_q;
    logic [7:0]    gate_mult_q;
    logic [7:0]    mult_act_q;
    logic [PW-1:0] pre_q;
    logic [7:0]    tick_q;
    logic          new_q, ovf_any_q;
    logic [7:0]    shadow_q;
    logic [7:0]    dout_q;

    logic [7:0]    off;
    logic          wr_ctrl, clear, rd_status;
    logic          tick, last, window_end;
    logic [7:0]    mult_eff;
    logic [7:0]    rd_data_d;
    logic          shadow_load;
    logic [7:0]    shadow_d;

    logic [CHANNELS-1:0] ovf_vec;
    logic [CHANNELS-1:0] pend_vec;
    logic [15:0]         res16 [CHANNELS];

    assign off        = address - BASE_ADDRESS;
    assign wr_ctrl    = w_en && (off == REG_CTRL);
    assign clear      = wr_ctrl && din[CTRL_CLR];
    assign rd_status  = r_en && (off == REG_STATUS);
    assign mult_eff   = (gate_mult_q == 8'd0) ? 8'd1 : gate_mult_q;
    assign tick       = en_q && (pre_q == PRE_LAST);
    assign last       = (tick_q == mult_act_q - 8'd1);
    assign window_end = tick && last;
    assign dout       = dout_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [COUNT_WIDTH-1:0] res;
        excom_channel #(.COUNT_WIDTH(COUNT_WIDTH)) u_ch (
            .clk_i       (clk),
            .rst_i       (rst),
            .excom_i     (excom[g]),
            .both_mode_i (both_q),
            .window_end_i(window_end),
            .clear_i     (clear),
            .enable_i    (en_q),
            .result_o    (res),
            .ovf_o       (ovf_vec[g]),
            .pending_o   (pend_vec[g])
        );
        assign res16[g] = 16'(res);
    end

    // Gate timer. The multiplier in use is only reloaded while idle, on clear
    // or at a window boundary, so GATE_MULT writes never stretch a live window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q      <= '0;
            tick_q     <= '0;
            mult_act_q <= 8'd1;
        end else if (clear || !en_q) begin
            pre_q      <= '0;
            tick_q     <= '0;
            mult_act_q <= mult_eff;
        end else begin
            pre_q <= tick ? '0 : pre_q + PW'(1);
            if (window_end) begin
                tick_q     <= '0;
                mult_act_q <= mult_eff;
            end else if (tick) begin
                tick_q <= tick_q + 8'd1;
            end
        end
    end

    always_comb begin
        rd_data_d   = '0;
        shadow_load = 1'b0;
        shadow_d    = '0;
        if (r_en) begin
            if (off == REG_CTRL) begin
                rd_data_d = {6'b0, both_q, en_q};
            end else if (off == REG_STATUS) begin
                rd_data_d = {6'b0, ovf_any_q, new_q};
            end else if (off == REG_GATE_MULT) begin
                rd_data_d = gate_mult_q;
            end else if (off == REG_OVF) begin
                rd_data_d = 8'(ovf_vec);
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (off == REG_RESULT_BASE + 8'(2 * i)) begin
                    rd_data_d   = res16[i][7:0];
                    shadow_load = 1'b1;
                    shadow_d    = res16[i][15:8];
                end
                if (off == REG_RESULT_BASE + 8'(2 * i + 1)) begin
                    rd_data_d = shadow_q;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q        <= CTRL_DEFAULT[CTRL_EN];
            both_q      <= CTRL_DEFAULT[CTRL_BOTH];
            gate_mult_q <= 8'd1;
            new_q       <= 1'b0;
            ovf_any_q   <= 1'b0;
            shadow_q    <= '0;
            dout_q      <= '0;
        end else begin
            dout_q <= rd_data_d;
            if (wr_ctrl) begin
                en_q   <= din[CTRL_EN];
                both_q <= din[CTRL_BOTH];
            end
            if (w_en && (off == REG_GATE_MULT)) begin
                gate_mult_q <= din;
            end
            if (clear) begin
                new_q     <= 1'b0;
                ovf_any_q <= 1'b0;
                shadow_q  <= '0;
            end else begin
                // A window end beats a coincident STATUS read-clear.
                if (window_end) begin
                    new_q     <= 1'b1;
                    ovf_any_q <= ovf_any_q | (|pend_vec);
                end else if (rd_status) begin
                    new_q     <= 1'b0;
                    ovf_any_q <= 1'b0;
                end
                if (shadow_load) begin
                    shadow_q <= shadow_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_excom_multi.sv
module tb_excom_multi;
    import excom_pkg::*;

    localparam int GC = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = '0;
    logic [7:0] address = '0;
    logic       w_en = 1'b0;
    logic       r_en = 1'b0;
    logic [7:0] dout_a, dout_s;
    logic [3:0] ex_a = '0;
    logic [0:0] ex_s = '0;

    excom_multi #(.BASE_ADDRESS(8'h00), .CHANNELS(4), .COUNT_WIDTH(12), .GATE_CYCLES(GC)) u_dut (
        .clk(clk), .rst(rst), .din(din), .address(address), .w_en(w_en), .r_en(r_en),
        .dout(dout_a), .excom(ex_a)
    );

    excom_multi #(.BASE_ADDRESS(8'h00), .CHANNELS(1), .COUNT_WIDTH(4), .GATE_CYCLES(GC)) u_sat (
        .clk(clk), .rst(rst), .din(din), .address(address), .w_en(w_en), .r_en(r_en),
        .dout(dout_s), .excom(ex_s)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int ncyc  = 0;
    int t0    = 0;
    int r0    = 0;

    always @(posedge clk) ncyc <= ncyc + 1;

    typedef struct {
        string      tag;
        bit         sel;
        logic [7:0] exp;
    } rd_exp_t;

    rd_exp_t sb[$];
    logic    rd_fire = 1'b0;

    always @(posedge clk) rd_fire <= r_en;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        rd_exp_t e;
        if (rd_fire) begin
            if (sb.size() == 0) begin
                check_val("sb_underflow", 8'(sb.size()), 8'd1);
            end else begin
                e = sb.pop_front();
                check_val(e.tag, e.sel ? dout_s : dout_a, e.exp);
            end
        end
    end

    function automatic logic [7:0] res_addr(input int ch, input bit hi);
        return REG_RESULT_BASE + 8'(2 * ch) + 8'(hi);
    endfunction

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        address = a;
        din     = d;
        w_en    = 1'b1;
        @(negedge clk);
        w_en    = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, input bit sel, input logic [7:0] exp, input string tag);
        rd_exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        address = a;
        r_en    = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        r_en    = 1'b0;
    endtask

    task automatic restart(input logic [7:0] ctrl);
        bus_write(REG_CTRL, ctrl | 8'h04);
        t0 = ncyc;
    endtask

    task automatic wait_until(input int t);
        while (ncyc < t) @(negedge clk);
    endtask

    task automatic pulse_a(input int ch, input int n);
        for (int i = 0; i < n; i++) begin
            ex_a[ch] = 1'b1;
            repeat (2) @(negedge clk);
            ex_a[ch] = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic pulse_s(input int n);
        for (int i = 0; i < n; i++) begin
            ex_s[0] = 1'b1;
            repeat (2) @(negedge clk);
            ex_s[0] = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int t1;
        repeat (2) @(negedge clk);
        check_val("rst_dout_a", dout_a, 8'h00);
        check_val("rst_dout_s", dout_s, 8'h00);
        rst = 1'b0;
        r0  = ncyc;

        // reset defaults
        bus_read(REG_STATUS, 0, 8'h00, "status_pre_window");
        bus_read(REG_CTRL, 0, 8'h01, "ctrl_reset");
        bus_read(REG_GATE_MULT, 0, 8'h01, "gate_mult_reset");
        wait_until(r0 + GC + 5);
        bus_read(REG_STATUS, 0, 8'h01, "status_first_window");
        bus_read(REG_STATUS, 1, 8'h00, "status_cleared_sat");
        bus_read(res_addr(0, 0), 0, 8'h00, "res0_idle");
        bus_read(REG_STATUS, 0, 8'h00, "status_cleared");
        bus_read(REG_CTRL, 0, 8'h01, "ctrl_after");

        // rate on ch0 / ch1
        restart(8'h01);
        pulse_a(0, 7);
        pulse_a(1, 3);
        wait_until(t0 + GC + 2);
        bus_write(REG_CTRL, 8'h00);
        bus_read(res_addr(0, 0), 0, 8'h07, "rate_res0_lo");
        bus_read(res_addr(0, 1), 0, 8'h00, "rate_res0_hi");
        bus_read(res_addr(1, 0), 0, 8'h03, "rate_res1_lo");
        bus_read(REG_OVF, 0, 8'h00, "rate_ovf");
        bus_read(REG_STATUS, 0, 8'h01, "rate_status");

        // both edges
        restart(8'h03);
        pulse_a(2, 5);
        wait_until(t0 + GC + 2);
        bus_write(REG_CTRL, 8'h00);
        bus_read(res_addr(2, 0), 0, 8'h0A, "both_res2");
        bus_read(REG_CTRL, 0, 8'h00, "ctrl_disabled");

        // GATE_MULT = 3 gives a 300-cycle window
        bus_write(REG_GATE_MULT, 8'h03);
        bus_read(REG_GATE_MULT, 0, 8'h03, "gate_mult_rd");
        restart(8'h01);
        pulse_a(0, 1);
        wait_until(t0 + GC + 5);
        bus_read(REG_STATUS, 0, 8'h00, "mult3_no_end_100");
        wait_until(t0 + 3 * GC - 3);
        bus_read(REG_STATUS, 0, 8'h00, "mult3_before_300");
        wait_until(t0 + 3 * GC + 1);
        bus_read(REG_STATUS, 0, 8'h01, "mult3_end");
        bus_read(res_addr(0, 0), 0, 8'h01, "mult3_res0");
        bus_write(REG_CTRL, 8'h00);
        bus_write(REG_GATE_MULT, 8'h01);

        // saturation on the 4-bit instance
        restart(8'h01);
        pulse_s(20);
        wait_until(t0 + GC + 2);
        bus_read(res_addr(0, 0), 1, 8'h0F, "sat_res");
        bus_read(REG_OVF, 1, 8'h01, "sat_ovf");
        bus_read(REG_STATUS, 1, 8'h03, "sat_status");
        wait_until(t0 + 2 * GC + 2);
        bus_read(REG_OVF, 1, 8'h00, "sat_ovf_clean");
        bus_read(res_addr(0, 0), 1, 8'h00, "sat_res_clean");
        bus_read(REG_STATUS, 1, 8'h01, "sat_status_clean");

        // edge detected on the window_end cycle, STATUS read on that cycle
        restart(8'h01);
        wait_until(t0 + GC - 3);
        ex_a[3] = 1'b1;
        wait_until(t0 + GC - 1);
        bus_read(REG_STATUS, 0, 8'h00, "bnd_status_same");
        bus_read(REG_STATUS, 0, 8'h01, "bnd_status_next");
        bus_read(res_addr(3, 0), 0, 8'h00, "bnd_old_window");
        ex_a[3] = 1'b0;
        wait_until(t0 + 2 * GC + 1);
        bus_read(res_addr(3, 0), 0, 8'h01, "bnd_new_window");

        // 12-bit result 0xABC, coherent low/high read
        bus_write(REG_GATE_MULT, 8'd30);
        restart(8'h03);
        for (int i = 0; i < 2748; i++) begin
            ex_a[0] = ~ex_a[0];
            @(negedge clk);
        end
        wait_until(t0 + 30 * GC + 2);
        bus_write(REG_CTRL, 8'h00);
        bus_read(res_addr(0, 0), 0, 8'hBC, "wide_lo");
        bus_read(res_addr(0, 1), 0, 8'h0A, "wide_hi");

        // CLR wipes results, STATUS and the shadow
        bus_write(REG_GATE_MULT, 8'h01);
        restart(8'h01);
        bus_read(res_addr(0, 1), 0, 8'h00, "clr_shadow");
        bus_read(res_addr(0, 0), 0, 8'h00, "clr_res0");
        bus_read(REG_STATUS, 0, 8'h00, "clr_status");

        // EN=0 retains results and produces no NEW
        pulse_a(1, 3);
        wait_until(t0 + GC + 2);
        bus_read(REG_STATUS, 0, 8'h01, "en_status_live");
        bus_read(res_addr(1, 0), 0, 8'h03, "en_res_live");
        bus_write(REG_CTRL, 8'h00);
        pulse_a(1, 4);
        t1 = ncyc;
        wait_until(t1 + 250);
        bus_read(REG_STATUS, 0, 8'h00, "en_off_status");
        bus_read(res_addr(1, 0), 0, 8'h03, "en_off_res");

        repeat (3) @(negedge clk);
        check_val("sb_drained", 8'(sb.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
